// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, PC step
// and the opcodes the control block decodes.
package mips_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: sequential step, or step plus a word-scaled branch offset.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc_nxt
);

  logic [31:0] pc_seq;

  // Wraps modulo 2^32; the offset is in words, so shifting keeps bits [1:0] clear.
  assign pc_seq = pc + PC_INC;
  assign pc_nxt = branch_taken ? (pc_seq + (branch_offset << 2)) : pc_seq;

endmodule

// File: rtl/instr_fetch.sv
// Two-state fetch: request a word at pc, hold it for decode until accepted,
// then advance pc (sequential or branch) and request again.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic [31:0]      pc_out,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  output logic [CNT_W-1:0] fetch_count
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_nxt;

  pc_next u_pc_next (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_nxt        (pc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // The first cycle out of reset only raises the request, so any
          // stale ack seen then is dropped.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr      <= imem_rdata;
            pc_out     <= pc;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc          <= pc_nxt;
            fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            inst_valid  <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a PC/count model
// derived from the fetch rules.
module tb_instr_fetch;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      instr;
  logic [5:0]       opcode;
  logic [31:0]      pc_out;
  logic             branch_taken;
  logic [31:0]      branch_offset;
  logic [CNT_W-1:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc;
  int          exp_cnt;

  instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instr         (instr),
    .opcode        (opcode),
    .pc_out        (pc_out),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},   32'd0);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_instr"}, instr,               32'd0);
    chk({tag, "_pcout"}, pc_out,              32'd0);
    chk({tag, "_cnt"},   {28'b0, fetch_count}, 32'd0);
  endtask

  // One complete fetch/handoff; called at a negedge with the DUT requesting exp_pc.
  task automatic do_fetch(input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                          input logic taken, input logic [31:0] off);
    logic [31:0] step;
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk("wait_req",   {31'b0, imem_req},   32'd1);
      chk("wait_addr",  imem_addr,           exp_pc);
      chk("wait_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    chk("ack_req",  {31'b0, imem_req}, 32'd1);
    chk("ack_addr", imem_addr,         exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_rdata = $urandom;
    for (int j = 0; j <= rdy_dly; j++) begin
      imem_ack      = 1'($urandom_range(0, 1));
      chk("hold_valid",  {31'b0, inst_valid}, 32'd1);
      chk("hold_req",    {31'b0, imem_req},   32'd0);
      chk("hold_instr",  instr,               rdata);
      chk("hold_opcode", {26'b0, opcode},     {26'b0, rdata[31:26]});
      chk("hold_pcout",  pc_out,              exp_pc);
      if (j < rdy_dly) begin
        inst_ready    = 1'b0;
        branch_taken  = 1'($urandom_range(0, 1));
        branch_offset = $urandom;
        @(negedge clk);
      end
    end
    inst_ready    = 1'b1;
    branch_taken  = taken;
    branch_offset = off;
    @(negedge clk);
    inst_ready    = 1'b0;
    branch_taken  = 1'($urandom_range(0, 1));
    branch_offset = $urandom;
    imem_ack      = 1'b0;
    step    = taken ? (32'd4 + (off << 2)) : 32'd4;
    exp_pc  = exp_pc + step;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("next_cnt",   {28'b0, fetch_count}, 32'(exp_cnt));
    chk("next_req",   {31'b0, imem_req},    32'd1);
    chk("next_addr",  imem_addr,            exp_pc);
    chk("next_valid", {31'b0, inst_valid},  32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    inst_ready    = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
    exp_pc        = 32'h0;
    exp_cnt       = 0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    imem_ack = 1'b1;
    rst_n    = 1'b1;
    @(negedge clk);
    // A leftover ack on the first edge after reset must not be captured.
    chk("first_req",   {31'b0, imem_req},   32'd1);
    chk("first_addr",  imem_addr,           32'd0);
    chk("first_instr", instr,               32'd0);
    chk("first_valid", {31'b0, inst_valid}, 32'd0);
    imem_ack = 1'b0;

    // LW at reset PC, single-cycle ack, immediate handoff
    do_fetch(32'h8C22_0004, 0, 0, 1'b0, 32'h0);
    // Delayed ack, then 5 stalled cycles with noisy branch inputs
    do_fetch(32'hAC01_0008, 3, 5, 1'b0, 32'h0);
    // pc=8: branch -3 -> 0, then +1 -> 8, then +2 -> 20
    chk("pc8", exp_pc, 32'd8);
    do_fetch(32'h1000_FFFD, 1, 1, 1'b1, 32'hFFFF_FFFD);
    chk("br_neg", imem_addr, 32'd0);
    do_fetch(32'h1000_0001, 0, 2, 1'b1, 32'h0000_0001);
    do_fetch(32'h1000_0002, 2, 0, 1'b1, 32'h0000_0002);
    chk("br_pos", imem_addr, 32'd20);
    // Jump to the top of the address space, then wrap sequentially to 0
    do_fetch(32'h1000_FFF9, 0, 0, 1'b1, 32'hFFFF_FFF9);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0020, 1, 1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'd0);

    // Randomized traffic; long enough to wrap the 4-bit fetch counter
    for (int k = 0; k < 24; k++) begin
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 32'($signed($urandom_range(0, 64)) - 32));
    end

    // Reset while a request is pending, followed by a late ack
    @(negedge clk);
    chk("mid_req_pre", {31'b0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreq");
    exp_pc  = 32'h0;
    exp_cnt = 0;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst_n      = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_instr", instr,               32'd0);
    chk("late_ack_valid", {31'b0, inst_valid}, 32'd0);
    chk("late_ack_addr",  imem_addr,           32'd0);
    do_fetch(32'h0000_0000, 0, 0, 1'b0, 32'h0);

    // Reset while holding an instruction
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("hold2_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midhold");
    @(negedge clk);
    inst_ready = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    chk("post_req",  {31'b0, imem_req},    32'd1);
    chk("post_addr", imem_addr,            32'd0);
    chk("post_cnt",  {28'b0, fetch_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
